mult_issue_ctrl: RTL and testbench
==================================

MULT_ISSUE_CTRL -- requirements
Module: mult_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning the maximum cycles spent waiting on the multiplier before an error is flagged.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  an operand request is present.
REQ-005 SHALL have port req_ready  output  1  the block accepts a request this cycle.
REQ-006 SHALL have port req_signed  input  1  1 = signed MULT, 0 = unsigned MULTU.
REQ-007 SHALL have port req_a  input  32  multiplicand operand.
REQ-008 SHALL have port req_b  input  32  multiplier operand.
REQ-009 SHALL have port mul_multiplicand  output  32  magnitude operand to the shift-add multiplier.
REQ-010 SHALL have port mul_multiplier  output  32  magnitude operand to the shift-add multiplier.
REQ-011 SHALL have port mul_run  output  1  start request to the multiplier.
REQ-012 SHALL have port mul_ready  input  1  multiplier finished; product valid.
REQ-013 SHALL have port mul_product  input  64  unsigned product from the multiplier.
REQ-014 SHALL have port hi / lo  output  32 each  registered upper and lower result words.
REQ-015 SHALL have port done  output  1  one-cycle pulse when hi/lo update.
REQ-016 SHALL have port err  output  1  sticky timeout flag, cleared only by the next accepted request or by reset.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> ARM -> WAIT -> FIX -> DONE -> IDLE.
REQ-018 In IDLE, req_ready SHALL be 1; req_ready SHALL be 0 in every other state.
REQ-019 A request SHALL be accepted when req_valid & req_ready; acceptance latches req_a, req_b, req_signed, clears err, and moves the FSM to ISSUE.
REQ-020 On acceptance with req_signed=1, the operand registers SHALL hold the absolute values, and neg SHALL be latched as req_a[31]^req_b[31].
REQ-021 The absolute value of 0x80000000 SHALL be 0x80000000, interpreted as unsigned.
REQ-022 With req_signed=0, operands SHALL pass through unchanged and neg SHALL be 0.
REQ-023 mul_multiplicand and mul_multiplier SHALL be held stable from ISSUE through WAIT.
REQ-024 mul_run SHALL be 1 in ISSUE and ARM and 0 in all other states.
REQ-025 ISSUE SHALL last exactly one cycle.
REQ-026 ARM SHALL wait for mul_ready==0, the multiplier's start acknowledge, then go to WAIT.
REQ-027 WAIT SHALL wait for mul_ready==1, then latch mul_product and go to FIX.
REQ-028 A cycle counter SHALL be cleared on entering ARM and increment in ARM and WAIT.
REQ-029 If the counter reaches TIMEOUT, the FSM SHALL set err=1, go to IDLE, and leave hi/lo unchanged, with no done pulse.
REQ-030 FIX SHALL last one cycle: {hi,lo} <= neg ? (~product + 1) mod 2^64 : product.
REQ-031 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-032 Total latency SHALL be multiplier busy time + 4 cycles (ISSUE, FIX, DONE, plus the ARM acknowledge cycle).
REQ-033 req_valid while busy SHALL be ignored; the request is not lost to the upstream, which holds it until req_ready.
REQ-034 hi/lo SHALL change only in FIX.

Reset
REQ-035 Reset SHALL asynchronously force: state=IDLE, req_ready=1, mul_run=0, operand registers=0, neg=0, counter=0, hi=0, lo=0, done=0, err=0.
REQ-036 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-037 The first request after reset deassertion SHALL be accepted normally.

Structure
REQ-038 A shared package mult_issue_pkg SHALL hold the state enum, data width 32, product width 64, and the TIMEOUT default.
REQ-039 One sub-module, mult_sign_fix (combinational 32-bit abs and 64-bit conditional negate), SHALL be used for both the operand and result paths.

Verification
REQ-040 Unsigned 3 x 5: with a stub multiplier, hi=0x00000000, lo=0x0000000F, and one done pulse.
REQ-041 Signed -7 (0xFFFFFFF9) x 3: the stub sees operands 7 and 3; result hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-042 Signed 0x80000000 x 0x80000000: hi=0x40000000, lo=0x00000000; unsigned 0xFFFFFFFF x 0xFFFFFFFF gives hi=0xFFFFFFFE, lo=0x00000001.
REQ-043 Backpressure: req_valid held during a busy operation keeps req_ready=0 until the cycle after DONE; the second request is then accepted and completes correctly.
REQ-044 Timeout: with mul_ready stuck low and TIMEOUT=40, err rises after 40 cycles, hi/lo keep their old values, no done pulse, and req_ready returns to 1.
REQ-045 Reset asserted in WAIT: all outputs reach reset values immediately, no done pulse, and a fresh 2 x 2 afterwards yields lo=4.

Source files
------------

// File: rtl/mult_issue_pkg.sv
// Shared types and sizes for the multiply issue controller.
package mult_issue_pkg;

  localparam int DATA_W          = 32;
  localparam int PROD_W          = 64;
  localparam int TIMEOUT_DEFAULT = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/mult_sign_fix.sv
// Sign handling around an unsigned multiplier: operand magnitudes on the way in,
// conditional two's-complement negation of the product on the way out.
module mult_sign_fix
  import mult_issue_pkg::*;
(
  input  logic              abs_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] abs_a,
  output logic [DATA_W-1:0] abs_b,
  input  logic              negate,
  input  logic [PROD_W-1:0] value,
  output logic [PROD_W-1:0] value_fixed
);

  // 0x80000000 negates to itself, which is the correct magnitude read as unsigned.
  assign abs_a       = (abs_en && a[DATA_W-1]) ? (~a + DATA_W'(1)) : a;
  assign abs_b       = (abs_en && b[DATA_W-1]) ? (~b + DATA_W'(1)) : b;
  assign value_fixed = negate ? (~value + PROD_W'(1)) : value;

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issues MULT/MULTU requests to a shift-add multiplier, restores the sign of the
// product into hi/lo and flags a sticky error if the multiplier never answers.
module mult_issue_ctrl
  import mult_issue_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] mul_multiplicand,
  output logic [DATA_W-1:0] mul_multiplier,
  output logic              mul_run,
  input  logic              mul_ready,
  input  logic [PROD_W-1:0] mul_product,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              done,
  output logic              err
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t            state;
  logic              neg;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              timed_out;
  logic [PROD_W-1:0] product_q;
  logic [PROD_W-1:0] product_fixed;
  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;

  assign cnt_next  = cnt + CNT_ONE;
  assign timed_out = (cnt_next == CNT_LIMIT);

  mult_sign_fix u_sign_fix (
    .abs_en      (req_signed),
    .a           (req_a),
    .b           (req_b),
    .abs_a       (abs_a),
    .abs_b       (abs_b),
    .negate      (neg),
    .value       (product_q),
    .value_fixed (product_fixed)
  );

  // Progress out of ARM/WAIT wins over the timeout when both happen on the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      req_ready        <= 1'b1;
      mul_run          <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      neg              <= 1'b0;
      cnt              <= '0;
      product_q        <= '0;
      hi               <= '0;
      lo               <= '0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            state            <= S_ISSUE;
            req_ready        <= 1'b0;
            mul_run          <= 1'b1;
            mul_multiplicand <= abs_a;
            mul_multiplier   <= abs_b;
            neg              <= req_signed & (req_a[DATA_W-1] ^ req_b[DATA_W-1]);
            err              <= 1'b0;
          end
        end
        S_ISSUE: begin
          state <= S_ARM;
          cnt   <= '0;
        end
        S_ARM: begin
          cnt <= cnt_next;
          if (!mul_ready) begin
            state   <= S_WAIT;
            mul_run <= 1'b0;
          end else if (timed_out) begin
            state     <= S_IDLE;
            mul_run   <= 1'b0;
            req_ready <= 1'b1;
            err       <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt_next;
          if (mul_ready) begin
            state     <= S_FIX;
            product_q <= mul_product;
          end else if (timed_out) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            err       <= 1'b1;
          end
        end
        S_FIX: begin
          state    <= S_DONE;
          {hi, lo} <= product_fixed;
          done     <= 1'b1;
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          mul_run   <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Scoreboard bench for mult_issue_ctrl with a variable-latency stub multiplier.
module tb_mult_issue_ctrl;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mcand;
    logic [31:0] mplier;
  } sb_item_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] mul_multiplicand;
  logic [31:0] mul_multiplier;
  logic        mul_run;
  logic        stub_ready;
  logic [63:0] stub_prod;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        err;

  int          checks = 0;
  int          failures = 0;
  int          pushed = 0;
  int          done_count = 0;
  sb_item_t    exp_q[$];
  sb_item_t    mon_item;
  logic [31:0] last_hi = 0;
  logic [31:0] last_lo = 0;
  logic        prev_done = 0;

  int          stub_busy = 2;
  bit          stub_stuck = 0;
  int          stub_left;
  logic [31:0] cap_a;
  logic [31:0] cap_b;

  mult_issue_ctrl #(.TIMEOUT(40)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_signed       (req_signed),
    .req_a            (req_a),
    .req_b            (req_b),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_run          (mul_run),
    .mul_ready        (stub_ready),
    .mul_product      (stub_prod),
    .hi               (hi),
    .lo               (lo),
    .done             (done),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub multiplier: idles ready, drops ready to acknowledge a run, stays busy a while.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_ready <= 1'b1;
      stub_left  <= 0;
      stub_prod  <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
    end else if (stub_stuck) begin
      stub_ready <= 1'b0;
      stub_left  <= 0;
    end else if (stub_ready && mul_run) begin
      stub_ready <= 1'b0;
      stub_left  <= stub_busy;
      cap_a      <= mul_multiplicand;
      cap_b      <= mul_multiplier;
      stub_prod  <= 64'(mul_multiplicand) * 64'(mul_multiplier);
    end else if (!stub_ready) begin
      if (stub_left == 0) stub_ready <= 1'b1;
      else                stub_left  <= stub_left - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: exact 64-bit products from integer arithmetic, magnitudes from sign tests.
  function automatic sb_item_t modelOp(input bit s, input logic [31:0] a, input logic [31:0] b);
    sb_item_t    it;
    longint      sa;
    longint      sb;
    longint      ma;
    longint      mb;
    logic [63:0] p;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      p  = sa * sb;
      it.mcand  = ma[31:0];
      it.mplier = mb[31:0];
    end else begin
      p = {32'b0, a} * {32'b0, b};
      it.mcand  = a;
      it.mplier = b;
    end
    it.hi = p[63:32];
    it.lo = p[31:0];
    return it;
  endfunction

  task automatic applyStimulus(input bit s, input logic [31:0] a, input logic [31:0] b,
                               input int busy, input bit expect_done);
    int       waited;
    sb_item_t it;
    waited = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_signed = s;
    req_a      = a;
    req_b      = b;
    stub_busy  = busy;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_wait actual=ready_low required=accepted_within_200");
      req_valid = 1'b0;
      return;
    end
    if (expect_done) begin
      it = modelOp(s, a, b);
      exp_q.push_back(it);
      pushed++;
      last_hi = it.hi;
      last_lo = it.lo;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_wait actual=pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_mul_run", mul_run, 0);
    checkOutput("rst_mcand", mul_multiplicand, 0);
    checkOutput("rst_mplier", mul_multiplier, 0);
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
  endtask

  // Monitor: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_done) begin
        checkOutput("done_width", done, 0);
        checkOutput("ready_after_done", req_ready, 1);
      end
      if (done) begin
        checkOutput("ready_in_done", req_ready, 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done actual=1 required=0 at %0t", $time);
        end else begin
          mon_item = exp_q.pop_front();
          done_count++;
          checkOutput("hi", hi, mon_item.hi);
          checkOutput("lo", lo, mon_item.lo);
          checkOutput("mcand", cap_a, mon_item.mcand);
          checkOutput("mplier", cap_b, mon_item.mplier);
        end
      end
    end
    prev_done <= reset ? 1'b0 : done;
  end

  initial begin : main
    logic [31:0] edge_vals [5];
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    edge_vals[0] = 32'h0000_0000;
    edge_vals[1] = 32'h0000_0001;
    edge_vals[2] = 32'h8000_0000;
    edge_vals[3] = 32'hFFFF_FFFF;
    edge_vals[4] = 32'h7FFF_FFFF;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    req_a      = '0;
    req_b      = '0;
    #12;
    checkResetValues();
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b0, 32'd3, 32'd5, 3, 1'b1);
    waitIdle();
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd3, 3, 1'b1);
    waitIdle();
    applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 0, 1'b1);
    waitIdle();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1);
    waitIdle();

    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      applyStimulus(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 6), 1'b1);
      if ($urandom_range(0, 1) == 1) waitIdle();
    end
    waitIdle();

    // Back-to-back requests: the second is held by the upstream while the first runs.
    applyStimulus(1'b1, 32'hFFFF_FFFE, 32'd7, 8, 1'b1);
    applyStimulus(1'b0, 32'd123456, 32'd654321, 2, 1'b1);
    waitIdle();

    $display("[TB] timeout scenario");
    stub_stuck = 1'b1;
    applyStimulus(1'b0, 32'd9, 32'd9, 0, 1'b0);
    n = 0;
    while (!err && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_cycles", n, 41);
    checkOutput("timeout_err", err, 1);
    checkOutput("timeout_ready", req_ready, 1);
    checkOutput("timeout_hi", hi, last_hi);
    checkOutput("timeout_lo", lo, last_lo);
    repeat (5) @(negedge clk);
    checkOutput("err_sticky", err, 1);
    stub_stuck = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 32'd11, 32'hFFFF_FFFF, 1, 1'b1);
    checkOutput("err_cleared", err, 0);
    waitIdle();

    $display("[TB] reset during WAIT");
    applyStimulus(1'b0, 32'd1000, 32'd1000, 10, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    pushed--;
    last_hi = '0;
    last_lo = '0;
    #1;
    checkResetValues();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 32'd2, 32'd2, 1, 1'b1);
    waitIdle();

    repeat (3) @(negedge clk);
    checkOutput("done_count", done_count, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
